// File: rtl/moore_arbiter_if.sv
// Requester/detector bundle for moore_arbiter: four serial requesters share one
// Moore sequence detector. The arbiter uses the slave modport; the requester/detector side uses master.
interface moore_arbiter_if;
    logic       ena;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] last;
    logic       det_hit;
    logic [3:0] gnt;
    logic       det_bit;
    logic       det_valid;
    logic       det_clr;
    logic [3:0] hit;
    logic       busy;
    logic       tmo;

    modport master (
        output ena, req, bit_in, last, det_hit,
        input  gnt, det_bit, det_valid, det_clr, hit, busy, tmo
    );

    modport slave (
        input  ena, req, bit_in, last, det_hit,
        output gnt, det_bit, det_valid, det_clr, hit, busy, tmo
    );
endinterface

// File: rtl/moore_arbiter.sv
// Round-robin arbiter granting one of four serial streams to a shared detector.
// Optional macro ARB_TIMEOUT_EN bounds each stream to 16 forwarded bits.
module moore_arbiter (
    input  logic            clk,
    input  logic            rst,
    moore_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] rr_ptr, rr_ptr_nxt;
    logic [1:0] pick;
    logic [3:0] gnt_q, gnt_nxt;
    logic [3:0] hit_q, hit_nxt;
    logic       det_bit_q, det_bit_nxt;
    logic       det_valid_q, det_valid_nxt;
    logic       det_clr_q, det_clr_nxt;
`ifdef ARB_TIMEOUT_EN
    logic [4:0] bit_cnt, bit_cnt_nxt;
    logic       tmo_q, tmo_nxt;
`endif

    // First set request at or after rr_ptr; walking offsets downward lets the
    // smallest offset win.
    always_comb begin
        pick = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        gnt_nxt       = gnt_q;
        det_bit_nxt   = det_bit_q;
        det_valid_nxt = 1'b0;
        det_clr_nxt   = 1'b0;
        hit_nxt       = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        bit_cnt_nxt   = bit_cnt;
        tmo_nxt       = 1'b0;
`endif
        if (bus.ena) begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner_nxt   = pick;
                        det_clr_nxt = 1'b1;
                        gnt_nxt     = 4'b0000;
                        state_nxt   = CLEAR;
                    end
                end
                CLEAR: begin
                    gnt_nxt   = 4'b0001 << owner;
                    state_nxt = STREAM;
`ifdef ARB_TIMEOUT_EN
                    bit_cnt_nxt = 5'd0;
`endif
                end
                STREAM: begin
                    if (bus.det_hit) hit_nxt = 4'b0001 << owner;
                    if (!bus.req[owner]) begin
                        gnt_nxt   = 4'b0000;
                        state_nxt = DRAIN;
                    end else begin
                        det_bit_nxt   = bus.bit_in[owner];
                        det_valid_nxt = 1'b1;
                        if (bus.last[owner]) begin
                            gnt_nxt   = 4'b0000;
                            state_nxt = DRAIN;
                        end
`ifdef ARB_TIMEOUT_EN
                        else if (bit_cnt == 5'd15) begin
                            gnt_nxt   = 4'b0000;
                            state_nxt = DRAIN;
                            tmo_nxt   = 1'b1;
                        end
                        bit_cnt_nxt = bit_cnt + 5'd1;
`endif
                    end
                end
                DRAIN: begin
                    if (bus.det_hit) hit_nxt = 4'b0001 << owner;
                    gnt_nxt    = 4'b0000;
                    rr_ptr_nxt = owner + 2'd1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 2'd0;
            rr_ptr      <= 2'd0;
            gnt_q       <= 4'b0000;
            hit_q       <= 4'b0000;
            det_bit_q   <= 1'b0;
            det_valid_q <= 1'b0;
            det_clr_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bit_cnt     <= 5'd0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_ptr_nxt;
            gnt_q       <= gnt_nxt;
            hit_q       <= hit_nxt;
            det_bit_q   <= det_bit_nxt;
            det_valid_q <= det_valid_nxt;
            det_clr_q   <= det_clr_nxt;
`ifdef ARB_TIMEOUT_EN
            bit_cnt     <= bit_cnt_nxt;
            tmo_q       <= tmo_nxt;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.hit       = hit_q;
    assign bus.det_bit   = det_bit_q;
    assign bus.det_valid = det_valid_q;
    assign bus.det_clr   = det_clr_q;
    assign bus.busy      = (state != IDLE);
`ifdef ARB_TIMEOUT_EN
    assign bus.tmo       = tmo_q;
`else
    assign bus.tmo       = 1'b0;
`endif
endmodule

// File: tb/tb_moore_arbiter.sv
// Self-checking bench for moore_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_moore_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    moore_arbiter_if bus();

    moore_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a granted transaction is "active" for a number of enabled
    // cycles; age 0 is the clear cycle, afterwards it streams until marked done,
    // then one more enabled cycle finishes it.
    bit         m_active, m_done;
    int         m_age, m_owner, m_ptr, m_nbits;
    logic [3:0] e_gnt, e_hit;
    logic       e_bit, e_valid, e_clr, e_tmo;

    logic [3:0] glog[$];
    logic [3:0] prev_gnt;
    int         nfwd, ntmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit found;
        int idx;
        if (rst) begin
            m_active = 0; m_done = 0; m_age = 0; m_owner = 0; m_ptr = 0; m_nbits = 0;
            e_gnt = 0; e_hit = 0; e_bit = 0; e_valid = 0; e_clr = 0; e_tmo = 0;
            return;
        end
        e_valid = 0; e_clr = 0; e_hit = 0; e_tmo = 0;
        if (!bus.ena) return;
        if (!m_active) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && bus.req[idx]) begin
                    found = 1;
                    m_owner = idx;
                end
            end
            if (found) begin
                m_active = 1; m_done = 0; m_age = 0; m_nbits = 0;
                e_clr = 1;
                e_gnt = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
            e_gnt = 4'(1 << m_owner);
        end else if (!m_done) begin
            if (bus.det_hit) e_hit = 4'(1 << m_owner);
            if (!bus.req[m_owner]) begin
                m_done = 1;
                e_gnt = 0;
            end else begin
                e_bit = bus.bit_in[m_owner];
                e_valid = 1;
                m_nbits++;
                if (bus.last[m_owner]) begin
                    m_done = 1;
                    e_gnt = 0;
                end else if (TMO_EN && m_nbits == 16) begin
                    m_done = 1;
                    e_gnt = 0;
                    e_tmo = 1;
                end
            end
        end else begin
            if (bus.det_hit) e_hit = 4'(1 << m_owner);
            m_active = 0;
            m_ptr = (m_owner + 1) % 4;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt", 32'(bus.gnt), 32'(e_gnt));
        chk("det_bit", 32'(bus.det_bit), 32'(e_bit));
        chk("det_valid", 32'(bus.det_valid), 32'(e_valid));
        chk("det_clr", 32'(bus.det_clr), 32'(e_clr));
        chk("hit", 32'(bus.hit), 32'(e_hit));
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("tmo", 32'(bus.tmo), 32'(e_tmo));
        if (bus.gnt != 0 && prev_gnt == 0) glog.push_back(bus.gnt);
        prev_gnt = bus.gnt;
        if (bus.det_valid === 1'b1) nfwd++;
        if (bus.tmo === 1'b1) ntmo++;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] b, input logic [3:0] l, input logic h);
        rst = 1'b0; bus.ena = 1'b1;
        bus.req = r; bus.bit_in = b; bus.last = l; bus.det_hit = h;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 10 && bus.busy !== 1'b0; n++) cyc();
        chk("idle_bound", 32'(bus.busy), 32'(0));
    endtask

    initial begin
        prev_gnt = 0; nfwd = 0; ntmo = 0;
        rst = 1'b1; bus.ena = 1'b0; bus.req = 0; bus.bit_in = 0; bus.last = 0; bus.det_hit = 0;
        cyc(); cyc();

        // Idle after reset with no requests.
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (6) cyc();
        chk("idle_gnt", 32'(bus.gnt), 32'(0));

        // Requester 2 streams 1,0,1.
        drive(4'b0100, 4'b0000, 4'b0000, 1'b0); cyc();
        chk("s035_clr", 32'(bus.det_clr), 32'(1));
        cyc();
        chk("s035_gnt", 32'(bus.gnt), 32'(4'b0100));
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0); cyc();
        chk("s035_bit1", 32'(bus.det_bit), 32'(1));
        drive(4'b0100, 4'b0000, 4'b0000, 1'b0); cyc();
        chk("s035_bit2", 32'(bus.det_bit), 32'(0));
        drive(4'b0100, 4'b0100, 4'b0100, 1'b0); cyc();
        chk("s035_bit3", 32'(bus.det_bit), 32'(1));
        chk("s035_drain_gnt", 32'(bus.gnt), 32'(0));
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); cyc();
        chk("s035_idle", 32'(bus.busy), 32'(0));
        drive(4'b1001, 4'b0000, 4'b0000, 1'b0); cyc(); cyc();
        chk("s035_ptr3", 32'(bus.gnt), 32'(4'b1000));
        drive(4'b1001, 4'b0000, 4'b1000, 1'b0); cyc();
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); wait_idle();

        // All four request, one-bit streams: order must be 0,1,2,3,0.
        glog.delete();
        for (int k = 0; k < 20; k++) begin
            drive(4'b1111, 4'($urandom_range(0, 15)), 4'b1111, 1'b0);
            cyc();
        end
        chk("rr_count", 32'(glog.size()), 32'(5));
        if (glog.size() >= 5) begin
            chk("rr_g0", 32'(glog[0]), 32'(4'b0001));
            chk("rr_g1", 32'(glog[1]), 32'(4'b0010));
            chk("rr_g2", 32'(glog[2]), 32'(4'b0100));
            chk("rr_g3", 32'(glog[3]), 32'(4'b1000));
            chk("rr_g4", 32'(glog[4]), 32'(4'b0001));
        end
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); wait_idle();

        // Requester 2 aborts after two bits.
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0); cyc(); cyc();
        cyc(); cyc();
        drive(4'b0000, 4'b0100, 4'b0000, 1'b0); cyc();
        chk("abort_valid", 32'(bus.det_valid), 32'(0));
        chk("abort_busy", 32'(bus.busy), 32'(1));
        cyc();
        drive(4'b1111, 4'b0000, 4'b0000, 1'b0); cyc(); cyc();
        chk("abort_ptr3", 32'(bus.gnt), 32'(4'b1000));
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); wait_idle();

        // det_hit held high across a requester-1 transaction.
        drive(4'b0010, 4'b0000, 4'b0000, 1'b1); cyc(); cyc();
        chk("hit_pre_stream", 32'(bus.hit), 32'(0));
        cyc(); cyc();
        chk("hit_stream", 32'(bus.hit), 32'(4'b0010));
        drive(4'b0010, 4'b0000, 4'b0010, 1'b1); cyc();
        drive(4'b0000, 4'b0000, 4'b0000, 1'b1); cyc(); cyc();
        chk("hit_idle", 32'(bus.hit), 32'(0));
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); wait_idle();

        // Twenty bits without last.
        drive(4'b0001, 4'b0000, 4'b0000, 1'b0); cyc(); cyc();
        nfwd = 0; ntmo = 0;
        for (int k = 0; k < 20 && bus.gnt == 4'b0001; k++) begin
            drive(4'b0001, 4'($urandom_range(0, 15)), 4'b0000, 1'b0);
            cyc();
        end
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); wait_idle();
        chk("long_fwd", 32'(nfwd), TMO_EN ? 32'(16) : 32'(20));
        chk("long_tmo", 32'(ntmo), TMO_EN ? 32'(1) : 32'(0));

        // ena low mid-stream, then reset mid-stream.
        drive(4'b1000, 4'b1000, 4'b0000, 1'b1); cyc(); cyc(); cyc();
        bus.ena = 1'b0; cyc(); cyc();
        chk("ena_hold_gnt", 32'(bus.gnt), 32'(4'b1000));
        bus.ena = 1'b1; cyc();
        rst = 1'b1; cyc();
        chk("rst_mid_gnt", 32'(bus.gnt), 32'(0));
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0); cyc();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.ena = ($urandom_range(0, 9) != 0);
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 7) == 0) bus.req[j] = ~bus.req[j];
                bus.last[j] = ($urandom_range(0, 5) == 0);
            end
            bus.bit_in = 4'($urandom_range(0, 15));
            bus.det_hit = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
